sau_mcm_pipe: RTL and testbench

Pipelined, multi-mode shift-add multiple-constant-multiplication unit for the DCT-II datapath. Each accepted sample is multiplied by every coefficient of one selectable DCT-II coefficient set: the 4-point set, or the odd-row set of the 8-, 16- or 32-point transform. Results are produced in parallel on 16 lanes. The unit feeds the butterfly/accumulate stage of the 2-D transform and carries valid/ready flow control with full backpressure.

---
 rtl/sau_mcm_pipe.sv | 130 +++++++++++++
 tb/tb_sau_mcm_pipe.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sau_mcm_pipe.sv
// sau_mcm_pipe: 3-stage shift-add multiple-constant multiplier for DCT-II coefficient sets.
// Optional SAU_MCM_ROUND_EN applies (p + 2^(SHIFT-1)) >>> SHIFT to every lane at S3.
module sau_mcm_pipe #(
    parameter int IW = 17,
    parameter int OW = 27,
    parameter int SHIFT = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IW-1:0]     in_x,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_mode,
    output logic [16*OW-1:0]  out_p
);
    if (IW + 7 > OW || SHIFT < 1 || SHIFT >= OW) begin : g_cfg_err
        $error("sau_mcm_pipe: need IW+7 <= OW and 1 <= SHIFT < OW");
    end

    logic              v1, v2, ld1, ld2, ld3;
    logic [1:0]        m1, m2;
    logic signed [OW-1:0] x1, t1, t3, t5, t7, t9;
    logic signed [OW-1:0] pr [16];
    logic signed [OW-1:0] lq [16];

    assign ld3 = !out_valid || out_ready;
    assign ld2 = !v2 || ld3;
    assign ld1 = !v1 || ld2;
    assign in_ready = ld1;

    // Every coefficient is one or two shifted copies of the odd multiples x, 3x, 5x, 7x, 9x.
    always_comb begin
        for (int k = 0; k < 16; k++) pr[k] = '0;
        case (m2)
            2'd0: begin
                pr[0] = t1 <<< 6;
                pr[1] = (t5 <<< 4) + t3;
                pr[2] = t9 <<< 2;
            end
            2'd1: begin
                pr[0] = (t5 <<< 4) + t9;
                pr[1] = (t9 <<< 3) + t3;
                pr[2] = (t3 <<< 4) + (t1 <<< 1);
                pr[3] = t9 <<< 1;
            end
            2'd2: begin
                pr[0] = (t9 <<< 3) + (t9 <<< 1);
                pr[1] = (t5 <<< 4) + t7;
                pr[2] = t5 <<< 4;
                pr[3] = (t1 <<< 6) + (t3 <<< 1);
                pr[4] = (t1 <<< 6) - t7;
                pr[5] = (t3 <<< 4) - t5;
                pr[6] = (t1 <<< 4) + t9;
                pr[7] = t9;
            end
            default: begin
                pr[0]  = (t9 <<< 3) + (t9 <<< 1);
                pr[1]  = (t9 <<< 3) + (t9 <<< 1);
                pr[2]  = (t5 <<< 4) + (t1 <<< 3);
                pr[3]  = (t5 <<< 4) + t5;
                pr[4]  = (t5 <<< 4) + (t1 <<< 1);
                pr[5]  = (t9 <<< 3) + (t3 <<< 1);
                pr[6]  = (t9 <<< 3) + t1;
                pr[7]  = (t1 <<< 6) + t3;
                pr[8]  = (t1 <<< 6) - t3;
                pr[9]  = (t3 <<< 4) + (t3 <<< 1);
                pr[10] = (t3 <<< 4) - (t1 <<< 1);
                pr[11] = (t9 <<< 2) + (t1 <<< 1);
                pr[12] = (t1 <<< 5) - t1;
                pr[13] = (t9 <<< 1) + (t1 <<< 2);
                pr[14] = t9 + (t1 <<< 2);
                pr[15] = t1 <<< 2;
            end
        endcase
    end

`ifdef SAU_MCM_ROUND_EN
    localparam logic signed [OW-1:0] HALF = OW'(1) <<< (SHIFT - 1);
    always_comb for (int k = 0; k < 16; k++) lq[k] = (pr[k] + HALF) >>> SHIFT;
`else
    always_comb for (int k = 0; k < 16; k++) lq[k] = pr[k];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            out_valid <= 1'b0;
            m1 <= '0;
            m2 <= '0;
            out_mode <= '0;
            x1 <= '0;
            t1 <= '0;
            t3 <= '0;
            t5 <= '0;
            t7 <= '0;
            t9 <= '0;
            out_p <= '0;
        end else begin
            if (ld1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    x1 <= {{(OW-IW){in_x[IW-1]}}, in_x};
                    m1 <= in_mode;
                end
            end
            if (ld2) begin
                v2 <= v1;
                if (v1) begin
                    m2 <= m1;
                    t1 <= x1;
                    t3 <= (x1 <<< 1) + x1;
                    t5 <= (x1 <<< 2) + x1;
                    t7 <= (x1 <<< 3) - x1;
                    t9 <= (x1 <<< 3) + x1;
                end
            end
            if (ld3) begin
                out_valid <= v2;
                if (v2) begin
                    out_mode <= m2;
                    for (int k = 0; k < 16; k++) out_p[k*OW +: OW] <= lq[k];
                end
            end
        end
    end
endmodule

// File: tb/tb_sau_mcm_pipe.sv
// tb_sau_mcm_pipe: scoreboard bench; accepted samples are queued and checked against a multiply model.
module tb_sau_mcm_pipe;
    localparam int IW = 17;
    localparam int OW = 27;
    localparam int SHIFT = 7;
    localparam int C0 [16] = '{64, 83, 36, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    localparam int C1 [16] = '{89, 75, 50, 18, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    localparam int C2 [16] = '{90, 87, 80, 70, 57, 43, 25, 9, 0, 0, 0, 0, 0, 0, 0, 0};
    localparam int C3 [16] = '{90, 90, 88, 85, 82, 78, 73, 67, 61, 54, 46, 38, 31, 22, 13, 4};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [IW-1:0] in_x = '0;
    logic [1:0] in_mode = '0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic [1:0] out_mode;
    logic [16*OW-1:0] out_p;

    typedef struct {longint x; logic [1:0] m;} smp_t;
    smp_t q [$];
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sau_mcm_pipe #(.IW(IW), .OW(OW), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
        .out_mode(out_mode), .out_p(out_p)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic longint model(input longint x, input logic [1:0] m, input int k);
        longint p;
        p = x * longint'(m == 2'd0 ? C0[k] : m == 2'd1 ? C1[k] : m == 2'd2 ? C2[k] : C3[k]);
`ifdef SAU_MCM_ROUND_EN
        p = (p + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
`endif
        return p;
    endfunction

    function automatic longint lane(input int k);
        logic signed [OW-1:0] v;
        v = out_p[k*OW +: OW];
        return longint'(v);
    endfunction

    task automatic offer(input longint x, input logic [1:0] m, output logic acc);
        @(negedge clk);
        in_valid = 1'b1;
        in_x = IW'(x);
        in_mode = m;
        #1;
        acc = in_ready;
        if (acc) q.push_back('{x, m});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : mon
        logic stalled;
        logic [16*OW-1:0] held;
        logic [1:0] hm;
        smp_t s;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) stalled = 1'b0;
            else begin
                if (stalled) chk("hold", longint'(out_valid && out_p == held && out_mode == hm), 1);
                if (out_valid && out_ready) begin
                    if (q.size() == 0) chk("stale", 1, 0);
                    else begin
                        s = q.pop_front();
                        chk("mode", longint'(out_mode), longint'(s.m));
                        for (int k = 0; k < 16; k++) chk($sformatf("lane%0d", k), lane(k), model(s.x, s.m, k));
                    end
                end
                stalled = out_valid && !out_ready;
                held = out_p;
                hm = out_mode;
            end
        end
    end

    initial begin : drv
        logic acc;
        int na;
        longint bx;
        logic signed [IW-1:0] rx;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", longint'(out_valid), 0);
        chk("rst_p_zero", longint'(out_p == '0), 1);
        chk("rst_mode", longint'(out_mode), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
        rst = 1'b0;
        out_ready = 1'b1;
        offer(1, 2'd3, acc);
        chk("basic_acc", longint'(acc), 1);
        na = 1;
        while (!out_valid && na < 10) begin
            @(posedge clk);
            #1;
            na++;
        end
        chk("latency", na, 3);
        offer(-65536, 2'd2, acc);
        offer(65535, 2'd0, acc);
        idle(5);
        out_ready = 1'b0;
        na = 0;
        bx = 1;
        for (int i = 0; i < 6; i++) begin
            offer(bx, 2'd1, acc);
            if (acc) begin
                na++;
                bx++;
            end
        end
        chk("bp_accepted", na, 3);
        chk("bp_in_ready", longint'(in_ready), 0);
        out_ready = 1'b1;
        na = 0;
        acc = 1'b0;
        while (!acc && na < 5) begin
            offer(bx, 2'd1, acc);
            na++;
        end
        chk("bp_release_acc", longint'(acc), 1);
        chk("bp_release_cycles", na, 1);
        idle(5);
        offer(7, 2'd3, acc);
        offer(8, 2'd2, acc);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        chk("rst_mid_valid", longint'(out_valid), 0);
        chk("rst_mid_p_zero", longint'(out_p == '0), 1);
        rst = 1'b0;
        idle(6);
        for (int i = 0; i < 8; i++) offer(2, (i % 2 == 1) ? 2'd3 : 2'd0, acc);
        idle(5);
        for (int i = 0; i < 60; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            rx = IW'($urandom);
            offer(longint'(rx), 2'($urandom_range(0, 3)), acc);
        end
        out_ready = 1'b1;
        na = 0;
        while (q.size() != 0 && na < 20) begin
            @(negedge clk);
            na++;
        end
        idle(2);
        chk("drain", longint'(q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
